// File: rtl/misr_bist_pkg.sv
// Shared types and defaults for the MISR BIST capture sequencer.
// Optional feature macro: MISR_BIST_MASK_EN (see misr_bist_ctrl).
package misr_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } bist_state_e;

    localparam int N_DEF     = 64;
    localparam int CNT_W_DEF = 32;
    localparam int LAT_DEF   = 2;

    // Value the MISR loads while its clear is asserted.
    localparam int unsigned SIG_SEED = 1;

endpackage

// File: rtl/bist_en_delay.sv
// LAT-deep single-bit delay line with synchronous active-high clear.
// LAT=0 degenerates to a wire.
module bist_en_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    generate
        if (LAT == 0) begin : g_pass
            assign dout = din;
        end else begin : g_sr
            logic [LAT-1:0] sr_q;
            logic [LAT-1:0] sr_d;

            // Shift one stage per cycle, new bit enters at bit 0.
            always_comb begin
                sr_d    = sr_q << 1;
                sr_d[0] = din;
            end

            // Stage registers; clear flushes everything in flight.
            always_ff @(posedge clk) begin
                if (clr) sr_q <= '0;
                else     sr_q <= sr_d;
            end

            assign dout = sr_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/misr_bist_ctrl.sv
// BIST capture sequencer: clears the MISR, runs the stimulus for M cycles,
// delays the MISR enable by the DUT latency, then samples and checks the
// signature. Define MISR_BIST_MASK_EN to add a per-bit don't-care mask.
module misr_bist_ctrl
    import misr_bist_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_cycles_i,
    input  logic [N-1:0]     golden_i,
    input  logic [N-1:0]     sig_i,
`ifdef MISR_BIST_MASK_EN
    input  logic [N-1:0]     mask_i,
`endif
    output logic             stim_en_o,
    output logic             misr_en_o,
    output logic             misr_clr_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [N-1:0]     sig_o
);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     sig_q, sig_d;
    logic             pass_q, pass_d;
    logic             drain_pulse;
    logic             drain_done;
    logic [N-1:0]     care;

`ifdef MISR_BIST_MASK_EN
    assign care = ~mask_i;
`else
    assign care = '1;
`endif

    // Next-state, counter and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_d       = sig_q;
        pass_d      = pass_q;
        drain_pulse = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    cnt_d   = num_cycles_i;
                    pass_d  = 1'b0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q != '0) begin
                    state_d = RUN;
                end else begin
                    drain_pulse = 1'b1;
                    state_d     = (LAT == 0) ? SAMPLE : DRAIN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    drain_pulse = 1'b1;
                    state_d     = (LAT == 0) ? SAMPLE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) state_d = SAMPLE;
            end
            SAMPLE: begin
                sig_d   = sig_i;
                pass_d  = ~|((sig_i ^ golden_i) & care);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sig_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    assign stim_en_o    = (state_q == RUN);
    assign misr_clr_n_o = (state_q != CLEAR);
    assign busy_o       = (state_q == CLEAR) || (state_q == RUN) ||
                          (state_q == DRAIN) || (state_q == SAMPLE);
    assign done_o       = (state_q == DONE);
    assign pass_o       = pass_q;
    assign sig_o        = sig_q;

    // MISR enable trails the stimulus enable by the DUT latency.
    bist_en_delay #(.LAT(LAT)) u_en_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (stim_en_o),
        .dout (misr_en_o)
    );

    // A marker launched on the last stimulus cycle pops out on the last
    // DRAIN cycle, i.e. when the final delayed enable reaches the MISR.
    bist_en_delay #(.LAT(LAT)) u_drain_dly (
        .clk  (clk),
        .clr  (rst),
        .din  (drain_pulse),
        .dout (drain_done)
    );

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Bench: two controllers (LAT=0 and LAT=2), each wired to a pattern source,
// a LAT-deep DUT data pipeline and a MISR model.
module tb_misr_bist_ctrl;

    localparam int N     = 64;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             start   [2];
    logic [CNT_W-1:0] num     [2];
    logic [N-1:0]     golden  [2];
    logic [N-1:0]     mask    [2];
    logic [N-1:0]     sig_i   [2];
    logic             stim_en [2];
    logic             misr_en [2];
    logic             clr_n   [2];
    logic             busy    [2];
    logic             done    [2];
    logic             pass    [2];
    logic [N-1:0]     sig_o   [2];

    logic [N-1:0] coeff;
    logic         zero_data;

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [N-1:0] pat(input int unsigned k);
        if (zero_data) return '0;
        return (64'(k) + 64'd1) * 64'h9E37_79B9_7F4A_7C15;
    endfunction

    function automatic logic [N-1:0] step(input logic [N-1:0] s, input logic [N-1:0] d);
        return {s[N-2:0], 1'b0} ^ (s[N-1] ? coeff : '0) ^ d;
    endfunction

    // Expected signature: seed folded with the first m response words.
    function automatic logic [N-1:0] ref_sig(input int m);
        logic [N-1:0] s;
        s = N'(1);
        for (int k = 0; k < m; k++) s = step(s, pat(k));
        return s;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_env
            localparam int L = 2 * g;
            int unsigned  pidx = 0;
            logic [N-1:0] dpipe [0:2];
            logic [N-1:0] misr = '0;

            assign dpipe[0] = stim_en[g] ? pat(pidx) : '0;
            assign sig_i[g] = misr;

            always @(posedge clk) begin
                dpipe[1] <= dpipe[0];
                dpipe[2] <= dpipe[1];
                if (!clr_n[g])       pidx <= 0;
                else if (stim_en[g]) pidx <= pidx + 1;
                if (!clr_n[g])       misr <= N'(1);
                else if (misr_en[g]) misr <= step(misr, dpipe[L]);
            end

            misr_bist_ctrl #(.N(N), .CNT_W(CNT_W), .LAT(L)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .start_i      (start[g]),
                .num_cycles_i (num[g]),
                .golden_i     (golden[g]),
                .sig_i        (sig_i[g]),
`ifdef MISR_BIST_MASK_EN
                .mask_i       (mask[g]),
`endif
                .stim_en_o    (stim_en[g]),
                .misr_en_o    (misr_en[g]),
                .misr_clr_n_o (clr_n[g]),
                .busy_o       (busy[g]),
                .done_o       (done[g]),
                .pass_o       (pass[g]),
                .sig_o        (sig_o[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ctl(input int i);
        return {stim_en[i], misr_en[i], clr_n[i], busy[i], done[i]};
    endfunction

    task automatic chk_reset(input int i, input string tag);
        chk({tag, "_ctl"}, N'(ctl(i)), N'(5'b00100));
        chk({tag, "_pass"}, N'(pass[i]), '0);
        chk({tag, "_sig"}, sig_o[i], '0);
    endtask

    // One capture run on controller i. k counts cycles after the accepting
    // edge. poke_k: pulse start with a new M; rst_k: assert reset there.
    task automatic run(input int i, input int m, input logic [N-1:0] gold,
                       input logic [N-1:0] mk, input int poke_k, input int rst_k);
        int L;
        logic [N-1:0] exp_sig, mk_eff;
        logic [4:0] exp_ctl;
        logic exp_pass;
        L = 2 * i;
`ifdef MISR_BIST_MASK_EN
        mk_eff = mk;
`else
        mk_eff = '0;
`endif
        exp_sig  = ref_sig(m);
        exp_pass = (((exp_sig ^ gold) & ~mk_eff) == '0);
        @(negedge clk);
        start[i] = 1'b1; num[i] = CNT_W'(m); golden[i] = gold; mask[i] = mk;
        for (int k = 1; k <= m + L + 5; k++) begin
            @(negedge clk);
            exp_ctl = {(k >= 2) && (k <= m + 1),
                       (k >= 2 + L) && (k <= m + 1 + L),
                       (k != 1),
                       (k <= m + 2 + L),
                       (k >= m + 3 + L)};
            chk($sformatf("ctl[%0d] m=%0d k=%0d", i, m, k), N'(ctl(i)), N'(exp_ctl));
            if (k == m + 3 + L || k == m + L + 5) begin
                chk($sformatf("sig[%0d] m=%0d k=%0d", i, m, k), sig_o[i], exp_sig);
                chk($sformatf("pass[%0d] m=%0d k=%0d", i, m, k), N'(pass[i]), N'(exp_pass));
            end
            start[i] = (k == poke_k);
            num[i]   = CNT_W'($urandom_range(1, 40));
            if (k >= m + 3 + L) begin
                golden[i] = ~gold;
                mask[i]   = ~mk;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset(i, "midrst");
                @(negedge clk);
                chk({"midrst_flush"}, N'(ctl(i)), N'(5'b00100));
                return;
            end
        end
        start[i] = 1'b0;
    endtask

    initial begin
        int i, m, L, pk;
        logic [N-1:0] gold, mk;
        for (int j = 0; j < 2; j++) begin
            start[j] = 1'b0; num[j] = '0; golden[j] = '0; mask[j] = '0;
        end
        coeff = '0; zero_data = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0, "por0");
        chk_reset(1, "por1");
        rst = 1'b0;

        // Directed cases with a plain shift-left MISR.
        run(0, 3, 64'h8, '0, 0, 0);
        run(0, 3, 64'h9, '0, 0, 0);
        run(1, 4, 64'h10, '0, 0, 0);
        run(0, 0, 64'h1, '0, 0, 0);
        run(1, 0, 64'h1, '0, 0, 0);
        run(1, 5, 64'h20, '0, 3, 0);
        run(1, 6, 64'h40, '0, 0, 4);
        run(0, 5, 64'h20, '0, 0, 3);
        run(1, 3, 64'h8, '0, 0, 0);
`ifdef MISR_BIST_MASK_EN
        run(0, 3, 64'h9, 64'h1, 0, 0);
        run(0, 3, 64'h9, 64'h0, 0, 0);
`endif

        // Randomized runs with live data and feedback taps.
        zero_data = 1'b0;
        for (int r = 0; r < 20; r++) begin
            coeff = {$urandom, $urandom};
            i  = $urandom_range(0, 1);
            L  = 2 * i;
            m  = $urandom_range(0, 24);
            mk = ($urandom_range(0, 1) == 1) ? N'(1) << $urandom_range(0, N - 1) : '0;
            if ($urandom_range(0, 1) == 1) gold = ref_sig(m) ^ mk;
            else                           gold = {$urandom, $urandom};
            pk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, m + 2 + L) : 0;
            run(i, m, gold, mk, pk, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
